// File: rtl/logic_result_queue.sv
// Registered bitwise-logic result stage: computes AND/OR/XOR/NOT and queues {result, flags} in 2 entries.
// Optional LOGIC_PARITY_EN adds a stored parity bit per entry and the out_parity port.
module logic_result_queue #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
`ifdef LOGIC_PARITY_EN
   output logic             out_zero,
   output logic             out_parity
`else
   output logic             out_zero
`endif
);

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

   typedef struct packed {
      logic [WIDTH-1:0] result;
`ifdef LOGIC_PARITY_EN
      logic             parity;
`endif
      logic             zero;
   } entry_t;

   state_t           state, state_next;
   logic             head, tail;
   entry_t           mem [2];
   entry_t           hd;
   entry_t           new_e;
   logic [WIDTH-1:0] res;
   logic             push, pop;

   assign in_ready  = (state != FULL);
   assign out_valid = (state != EMPTY);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_comb begin
      res = '0;
      case (op)
         2'b00:   res = a & b;
         2'b01:   res = a | b;
         2'b10:   res = a ^ b;
         default: res = ~a;
      endcase
      new_e        = '0;
      new_e.result = res;
      new_e.zero   = (res == '0);
`ifdef LOGIC_PARITY_EN
      new_e.parity = ^res;
`endif
   end

   always_comb begin
      state_next = state;
      case (state)
         EMPTY:   if (push) state_next = ONE;
         ONE: begin
            if (push && !pop)      state_next = FULL;
            else if (pop && !push) state_next = EMPTY;
         end
         FULL:    if (pop) state_next = ONE;
         default: state_next = EMPTY;
      endcase
   end

   // hd mirrors the entry the head pointer will select, so outputs come straight from flops
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= EMPTY;
         head   <= 1'b0;
         tail   <= 1'b0;
         mem[0] <= '0;
         mem[1] <= '0;
         hd     <= '0;
      end else begin
         state <= state_next;
         if (push) begin
            mem[tail] <= new_e;
            tail      <= ~tail;
         end
         if (pop) head <= ~head;
         if (push && (state == EMPTY || (state == ONE && pop)))
            hd <= new_e;
         else if (pop && state == FULL)
            hd <= mem[~head];
      end
   end

   assign out_result = hd.result;
   assign out_zero   = hd.zero;
`ifdef LOGIC_PARITY_EN
   assign out_parity = hd.parity;
`endif

endmodule

// File: tb/tb_logic_result_queue.sv
// Randomized + directed bench for logic_result_queue against a queue-based reference model.
module tb_logic_result_queue;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic [1:0]       op = 2'b00;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_result;
   logic             out_zero;
`ifdef LOGIC_PARITY_EN
   logic             out_parity;
`endif

   logic [WIDTH-1:0] mq [$];
   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   logic_result_queue #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result),
`ifdef LOGIC_PARITY_EN
      .out_parity(out_parity),
`endif
      .out_zero(out_zero)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] ref_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                                input logic [1:0] o);
      case (o)
         2'd0:    return x & y;
         2'd1:    return x | y;
         2'd2:    return x ^ y;
         default: return ~x;
      endcase
   endfunction

   task automatic check_outs(input string tag);
      chk({tag, ".in_ready"}, in_ready, mq.size() != 2);
      chk({tag, ".out_valid"}, out_valid, mq.size() != 0);
      if (mq.size() != 0) begin
         chk({tag, ".result"}, out_result, mq[0]);
         chk({tag, ".zero"}, out_zero, mq[0] == '0);
`ifdef LOGIC_PARITY_EN
         chk({tag, ".parity"}, out_parity, ^mq[0]);
`endif
      end
   endtask

   // Drive one cycle of stimulus (called just after a falling edge), update the model at the
   // rising edge, and check outputs at the next falling edge.
   task automatic cycle(input string tag, input logic iv, input logic [WIDTH-1:0] av,
                        input logic [WIDTH-1:0] bv, input logic [1:0] ov, input logic ordy);
      logic do_push, do_pop;
      in_valid = iv; a = av; b = bv; op = ov; out_ready = ordy;
      do_push = iv && (mq.size() < 2);
      do_pop  = ordy && (mq.size() > 0);
      @(posedge clk);
      if (!rst) begin
         if (do_pop) void'(mq.pop_front());
         if (do_push) mq.push_back(ref_op(av, bv, ov));
      end
      @(negedge clk);
      check_outs(tag);
   endtask

   task automatic reset_outs_check(input string tag);
      chk({tag, ".in_ready"}, in_ready, 1);
      chk({tag, ".out_valid"}, out_valid, 0);
      chk({tag, ".result"}, out_result, 0);
      chk({tag, ".zero"}, out_zero, 0);
`ifdef LOGIC_PARITY_EN
      chk({tag, ".parity"}, out_parity, 0);
`endif
   endtask

   localparam logic [WIDTH-1:0] VA = 32'hCA981547;
   localparam logic [WIDTH-1:0] VB = 32'h3567EAB9;

   initial begin
      // push attempted while in reset must be ignored
      in_valid = 1'b1;
      repeat (2) @(negedge clk);
      reset_outs_check("rst");
      in_valid = 1'b0;
      rst = 1'b0;

      // directed vectors, out_ready high
      cycle("and", 1, VA, VB, 2'd0, 1);
      chk("and.const", out_result, 32'h00000001);
`ifdef LOGIC_PARITY_EN
      chk("and.par_const", out_parity, 1);
`endif
      cycle("or", 1, VA, VB, 2'd1, 1);
      chk("or.const", out_result, 32'hFFFFFFFF);
      cycle("xor", 1, VA, VB, 2'd2, 1);
      chk("xor.const", out_result, 32'hFFFFFFFE);
      cycle("xor0", 1, VB, VB, 2'd2, 1);
      chk("xor0.zero", out_zero, 1);
      cycle("not", 1, VB, VB, 2'd3, 1);
      chk("not.const", out_result, 32'hCA981546);
      cycle("drain", 0, '0, '0, 2'd0, 1);

      // back-pressure: three pushes with out_ready low
      cycle("stall1", 1, VA, VB, 2'd0, 0);
      cycle("stall2", 1, VA, VB, 2'd1, 0);
      chk("stall2.full", in_ready, 0);
      cycle("stall3", 1, VA, VB, 2'd2, 0);
      chk("stall3.head", out_result, 32'h00000001);
      cycle("pop1", 1, VA, VB, 2'd2, 1);
      chk("pop1.ready", in_ready, 1);
      cycle("pop2", 0, '0, '0, 2'd0, 1);
      cycle("pop3", 0, '0, '0, 2'd0, 1);

      // count=1, simultaneous push and pop
      cycle("one", 1, VA, VB, 2'd1, 0);
      cycle("pp", 1, VB, VB, 2'd3, 1);
      chk("pp.head", out_result, 32'hCA981546);
      cycle("pp.drain", 0, '0, '0, 2'd0, 1);

      // asynchronous reset with two entries held
      cycle("fill1", 1, VA, VB, 2'd0, 0);
      cycle("fill2", 1, VA, VB, 2'd3, 0);
      #2 rst = 1'b1;
      #1 reset_outs_check("arst");
      mq.delete();
      @(negedge clk);
      rst = 1'b0;
      check_outs("arst.rel");

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic [1:0] rop;
         rop = 2'($urandom_range(0, 3));
         cycle("rnd", ($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 7) == 0) ? '0 : $urandom,
               rop, ($urandom_range(0, 2) != 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
